cache_dm: RTL

Parametrised direct-mapped, write-through, no-write-allocate cache inserted between one CPU memory port (instruction or data side) and the slow shared memory. It generalises the CPU's fixed single-word memory interface: word width, line count and line length are set by parameters, and a ready/ack handshake replaces fixed-latency access. It also adds hit and access counters for performance measurement. Two instances are planned, one per CPU port (i_ and d_).

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_dm_array.sv | 52 +++++
 rtl/cache_dm.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: controller states and
// helpers that size the offset/index/tag fields from the geometry parameters.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } cacheState_e;

    // Width of an address field selecting one of n entries; 0 when n == 1.
    function automatic int fieldWidth(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Storage width for a field that may be zero bits wide.
    function automatic int storeWidth(input int w);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/cache_dm_array.sv
// Tag, valid and data storage for the direct-mapped cache. Combinational
// read port; synchronous word-write and line-set ports. Reset clears valid only.
module cache_dm_array
    import cache_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4,
    parameter int TAG_BITS   = 12
) (
    input  logic                                        clk,
    input  logic                                        rstN,
    input  logic [storeWidth(fieldWidth(NUM_LINES))-1:0]  rdIndex,
    input  logic [storeWidth(fieldWidth(LINE_WORDS))-1:0] rdOffset,
    output logic                                        rdValid,
    output logic [TAG_BITS-1:0]                         rdTag,
    output logic [WORD_SIZE-1:0]                        rdWord,
    input  logic                                        wordWe,
    input  logic [storeWidth(fieldWidth(NUM_LINES))-1:0]  wordIndex,
    input  logic [storeWidth(fieldWidth(LINE_WORDS))-1:0] wordOffset,
    input  logic [WORD_SIZE-1:0]                        wordData,
    input  logic                                        lineSet,
    input  logic [storeWidth(fieldWidth(NUM_LINES))-1:0]  lineIndex,
    input  logic [TAG_BITS-1:0]                         lineTag
);

    logic [WORD_SIZE-1:0] dataMem [NUM_LINES][LINE_WORDS];
    logic [TAG_BITS-1:0]  tagMem  [NUM_LINES];
    logic [NUM_LINES-1:0] validBits;

    assign rdValid = validBits[rdIndex];
    assign rdTag   = tagMem[rdIndex];
    assign rdWord  = dataMem[rdIndex][rdOffset];

    always_ff @(posedge clk) begin
        if (wordWe) begin
            dataMem[wordIndex][wordOffset] <= wordData;
        end
        if (lineSet) begin
            tagMem[lineIndex] <= lineTag;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            validBits <= '0;
        end else if (lineSet) begin
            validBits[lineIndex] <= 1'b1;
        end
    end

endmodule

// File: rtl/cache_dm.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU port
// and slow shared memory, with ready/ack handshakes and access/hit counters.
module cache_dm
    import cache_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 ready,
    output logic                 mem_readM,
    output logic                 mem_writeM,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [15:0]          num_access,
    output logic [15:0]          num_hit
);

    localparam int OFF_W    = fieldWidth(LINE_WORDS);
    localparam int IDX_W    = fieldWidth(NUM_LINES);
    localparam int OFF_BITS = storeWidth(OFF_W);
    localparam int IDX_BITS = storeWidth(IDX_W);
    localparam int TAG_BITS = storeWidth(WORD_SIZE - OFF_W - IDX_W);

    localparam logic [WORD_SIZE-1:0] LW_DIV    = WORD_SIZE'(LINE_WORDS);
    localparam logic [WORD_SIZE-1:0] NL_DIV    = WORD_SIZE'(NUM_LINES);
    localparam logic [WORD_SIZE-1:0] SPAN_DIV  = WORD_SIZE'(LINE_WORDS * NUM_LINES);
    localparam logic [OFF_BITS-1:0]  LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

    // Field extraction by division keeps zero-width offset/index fields legal.
    function automatic logic [OFF_BITS-1:0] addrOffset(input logic [WORD_SIZE-1:0] a);
        logic [WORD_SIZE-1:0] t;
        t = a % LW_DIV;
        return t[OFF_BITS-1:0];
    endfunction

    function automatic logic [IDX_BITS-1:0] addrIndex(input logic [WORD_SIZE-1:0] a);
        logic [WORD_SIZE-1:0] t;
        t = (a / LW_DIV) % NL_DIV;
        return t[IDX_BITS-1:0];
    endfunction

    function automatic logic [TAG_BITS-1:0] addrTag(input logic [WORD_SIZE-1:0] a);
        logic [WORD_SIZE-1:0] t;
        t = a / SPAN_DIV;
        return t[TAG_BITS-1:0];
    endfunction

    cacheState_e          state;
    cacheState_e          nextState;
    logic [OFF_BITS-1:0]  wordCnt;
    logic                 missPending;
    logic [WORD_SIZE-1:0] fillBase;

    logic [OFF_BITS-1:0]  cpuOffset;
    logic [IDX_BITS-1:0]  cpuIndex;
    logic [TAG_BITS-1:0]  cpuTag;
    logic [IDX_BITS-1:0]  fillIndex;
    logic [TAG_BITS-1:0]  fillTag;

    logic                 arrValid;
    logic [TAG_BITS-1:0]  arrTag;
    logic [WORD_SIZE-1:0] arrWord;
    logic                 hit;
    logic                 startFill;
    logic                 fillAck;
    logic                 lastWord;
    logic                 wordWe;
    logic                 lineSet;
    logic [IDX_BITS-1:0]  wordIndex;
    logic [OFF_BITS-1:0]  wordOffset;
    logic [WORD_SIZE-1:0] wordData;

    assign cpuOffset = addrOffset(address);
    assign cpuIndex  = addrIndex(address);
    assign cpuTag    = addrTag(address);
    assign fillIndex = addrIndex(fillBase);
    assign fillTag   = addrTag(fillBase);

    assign hit       = arrValid && (arrTag == cpuTag);
    assign startFill = (state == IDLE) && readM && !writeM && !hit;
    assign fillAck   = (state == FILL) && mem_ack;
    assign lastWord  = (wordCnt == LAST_WORD);

    // Fill data and write-hit data share the single word-write port.
    assign wordWe     = fillAck || ((state == IDLE) && writeM && mem_ack && hit);
    assign wordIndex  = (state == FILL) ? fillIndex : cpuIndex;
    assign wordOffset = (state == FILL) ? wordCnt : cpuOffset;
    assign wordData   = (state == FILL) ? mem_rdata : wdata;
    assign lineSet    = fillAck && lastWord;

    cache_dm_array #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_LINES (NUM_LINES),
        .LINE_WORDS(LINE_WORDS),
        .TAG_BITS  (TAG_BITS)
    ) uArray (
        .clk       (Clk),
        .rstN      (Reset_N),
        .rdIndex   (cpuIndex),
        .rdOffset  (cpuOffset),
        .rdValid   (arrValid),
        .rdTag     (arrTag),
        .rdWord    (arrWord),
        .wordWe    (wordWe),
        .wordIndex (wordIndex),
        .wordOffset(wordOffset),
        .wordData  (wordData),
        .lineSet   (lineSet),
        .lineIndex (fillIndex),
        .lineTag   (fillTag)
    );

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (startFill) nextState = FILL;
            FILL: if (fillAck && lastWord) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Every output is forced low while Reset_N is asserted.
    always_comb begin
        ready       = 1'b0;
        rdata       = '0;
        mem_readM   = 1'b0;
        mem_writeM  = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        if (Reset_N) begin
            rdata     = arrWord;
            mem_wdata = wdata;
            case (state)
                IDLE: begin
                    mem_writeM  = writeM;
                    mem_address = address;
                    ready       = writeM ? mem_ack : (readM && hit);
                end
                FILL: begin
                    mem_readM   = 1'b1;
                    mem_address = fillBase + WORD_SIZE'(wordCnt);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wordCnt     <= '0;
            missPending <= 1'b0;
            num_access  <= '0;
            num_hit     <= '0;
        end else begin
            if (startFill) begin
                wordCnt <= '0;
            end else if (fillAck) begin
                wordCnt <= wordCnt + OFF_BITS'(1);
            end
            if (ready) begin
                missPending <= 1'b0;
            end else if (startFill) begin
                missPending <= 1'b1;
            end
            if (ready) begin
                num_access <= num_access + 16'd1;
            end
            if (ready && readM && !missPending) begin
                num_hit <= num_hit + 16'd1;
            end
        end
    end

    // The line base is captured so a fill finishes even if readM drops.
    always_ff @(posedge Clk) begin
        if (startFill) begin
            fillBase <= address - (address % LW_DIV);
        end
    end

endmodule
